// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered index/one-hot grant and a forced dead cycle between grants.
// Optional hold-timeout forced release is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] req_i,
    output logic       grant_valid_o,
    output logic [2:0] grant_idx_o,
    output logic [7:0] grant_oh_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic       grant_valid_q;
    logic [2:0] grant_idx_q;
    logic [7:0] grant_oh_q;
    logic [2:0] ptr_q;

    logic       pick_vld_d;
    logic [2:0] pick_idx_d;

    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        dec3to8 = 8'b0000_0001 << idx;
    endfunction

    // Search ptr+1 .. ptr+8 (wrapping); walking backwards lets the nearest hit overwrite farther ones.
    always_comb begin
        logic [2:0] cand;
        cand       = '0;
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr_q + 3'(k);
            if (req_i[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

    logic [3:0] hold_cnt_q;
    logic       timeout_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            grant_oh_q    <= '0;
            ptr_q         <= 3'd7;
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        state_q       <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= pick_idx_d;
                        grant_oh_q    <= dec3to8(pick_idx_d);
                        hold_cnt_q    <= '0;
                    end
                end
                GRANT: begin
                    // A voluntary release wins over the limit, so no timeout pulse in that case.
                    if (!req_i[grant_idx_q] || hold_cnt_q == HOLD_LIM) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        grant_idx_q   <= '0;
                        grant_oh_q    <= '0;
                        ptr_q         <= grant_idx_q;
                        timeout_q     <= req_i[grant_idx_q];
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout_o = timeout_q;
`else
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            grant_oh_q    <= '0;
            ptr_q         <= 3'd7;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        state_q       <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= pick_idx_d;
                        grant_oh_q    <= dec3to8(pick_idx_d);
                    end
                end
                GRANT: begin
                    if (!req_i[grant_idx_q]) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        grant_idx_q   <= '0;
                        grant_oh_q    <= '0;
                        ptr_q         <= grant_idx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign grant_valid_o = grant_valid_q;
    assign grant_idx_o   = grant_idx_q;
    assign grant_oh_o    = grant_oh_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: vector table for single-cycle behaviour, hand sequences for rotation and hold limits.
module tb_rr_arbiter8;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 15;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.HOLD_MAX(HM)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_i        (req),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx),
        .grant_oh_o   (grant_oh),
        .timeout_o    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       exp_valid;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input logic r, input logic [7:0] q);
        rst_n = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ev, input logic [2:0] ei, input logic et);
        logic [7:0] eoh;
        eoh = ev ? (8'b0000_0001 << ei) : 8'h00;
        if (!ev) ei = 3'd0;
        checks++;
        if (grant_valid !== ev || grant_idx !== ei || grant_oh !== eoh || timeout !== et) begin
            errors++;
            $display("FAIL %s: got valid=%0b idx=%0d oh=%02h to=%0b, want valid=%0b idx=%0d oh=%02h to=%0b",
                     name, grant_valid, grant_idx, grant_oh, timeout, ev, ei, eoh, et);
        end
    endtask

    initial begin
        int cur;
        rst_n = 1'b0;
        req   = 8'h00;

        vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd0}); // reset
        vecs.push_back('{1'b0, 8'h04, 1'b0, 3'd0}); // reset dominates req
        vecs.push_back('{1'b1, 8'h04, 1'b1, 3'd2}); // single request
        vecs.push_back('{1'b1, 8'h04, 1'b1, 3'd2});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // release, ptr=2
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h03, 1'b1, 3'd0}); // search 3..7 then 0
        vecs.push_back('{1'b1, 8'h02, 1'b0, 3'd0}); // release, ptr=0
        vecs.push_back('{1'b1, 8'h02, 1'b1, 3'd1});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // ptr=1
        vecs.push_back('{1'b1, 8'h80, 1'b1, 3'd7});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // ptr=7
        vecs.push_back('{1'b1, 8'h80, 1'b1, 3'd7}); // ptr=7, req=80 -> 7
        vecs.push_back('{1'b1, 8'hC0, 1'b1, 3'd7}); // no preemption
        vecs.push_back('{1'b1, 8'h40, 1'b0, 3'd0}); // release, ptr=7
        vecs.push_back('{1'b1, 8'h40, 1'b1, 3'd6});
        vecs.push_back('{1'b1, 8'hC0, 1'b1, 3'd6});
        vecs.push_back('{1'b1, 8'h80, 1'b0, 3'd0}); // release, ptr=6
        vecs.push_back('{1'b1, 8'hC0, 1'b1, 3'd7}); // ptr=6, req=C0 -> 7
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // ptr=7
        vecs.push_back('{1'b1, 8'h40, 1'b1, 3'd6});
        vecs.push_back('{1'b1, 8'h41, 1'b1, 3'd6});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // ptr=6
        vecs.push_back('{1'b1, 8'h41, 1'b1, 3'd0}); // wrap past 7 to 0, not 6
        vecs.push_back('{1'b1, 8'h41, 1'b1, 3'd0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0}); // ptr=0
        vecs.push_back('{1'b1, 8'h08, 1'b0, 3'd0}); // dead-cycle not needed here: first IDLE edge grants
        vecs.push_back('{1'b1, 8'h20, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h20, 1'b1, 3'd5});
        vecs.push_back('{1'b1, 8'h20, 1'b1, 3'd5});
        vecs.push_back('{1'b0, 8'h20, 1'b0, 3'd0}); // reset mid-grant
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 3'd0}); // reset pointer -> 0
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 3'd0});

        // Row 26->27 above: req=08 at the edge after the release grants 3; fix expectation entries accordingly.
        vecs[26] = '{1'b1, 8'h08, 1'b1, 3'd3};
        vecs[27] = '{1'b1, 8'h20, 1'b0, 3'd0};

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].req);
            chk($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, 1'b0);
        end

        // Full contention: each owner holds 2 cycles, drops its bit one cycle, then re-requests.
        for (int g = 0; g < 16; g++) begin
            cur = g % 8;
            step(1'b1, 8'hFF & ~(8'h01 << cur));
            chk($sformatf("rot_rel%0d", g), 1'b0, 3'd0, 1'b0);
            step(1'b1, 8'hFF);
            chk($sformatf("rot_gnt%0d", g), 1'b1, 3'((g + 1) % 8), 1'b0);
            step(1'b1, 8'hFF);
            chk($sformatf("rot_hold%0d", g), 1'b1, 3'((g + 1) % 8), 1'b0);
        end

        step(1'b0, 8'h00);
        chk("rst2", 1'b0, 3'd0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
        // HOLD_MAX=4: owner holds 4 cycles, forced release pulses timeout, other requester follows.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 8'h03);
                chk($sformatf("to_hold%0d_%0d", r, c), 1'b1, 3'(r % 2), 1'b0);
            end
            step(1'b1, 8'h03);
            chk($sformatf("to_pulse%0d", r), 1'b0, 3'd0, 1'b1);
        end
        // Release coinciding with the limit edge is a normal release.
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 8'h01);
            chk($sformatf("to_edge_hold%0d", c), 1'b1, 3'd0, 1'b0);
        end
        step(1'b1, 8'h00);
        chk("to_edge_rel", 1'b0, 3'd0, 1'b0);
`else
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 8'h03);
            chk($sformatf("noto_hold%0d", c), 1'b1, 3'd0, 1'b0);
        end
        step(1'b1, 8'h00);
        chk("noto_rel", 1'b0, 3'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
